// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit
//   Instruction-fetch front end for the pipelined MIPS core. It owns the fetch
//   PC and issues pipelined requests to a variable-latency, in-order
//   instruction memory. Responses are buffered in a QDEPTH-entry prefetch
//   queue. The queue head is presented to the Fetch/Decode register as
//   {instr, pc, pc+4} under a valid/ready handshake. A redirect (branch, jump
//   or jr) flushes all speculative state and restarts fetch at the new PC.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   imem_req_valid/_addr     fetch request toward memory (addr = fetch PC)
//   imem_req_ready           memory accepts the request this cycle
//   imem_rsp_valid/_data     in-order response, no backpressure
//   redirect_valid/_pc       flush and restart fetch at redirect_pc (word aligned)
//   fd_valid/_instr/_pc      head instruction toward decode
//   fd_pc_plus4              fd_pc + 4, wrapping
//   fd_ready                 decode accepts the head entry
//   err_rsp                  sticky: response seen with nothing outstanding
module mips_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                QDEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              fd_valid,
  output logic [31:0]       fd_instr,
  output logic [ADDR_W-1:0] fd_pc,
  output logic [ADDR_W-1:0] fd_pc_plus4,
  input  logic              fd_ready,
  output logic              err_rsp
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] QDEPTH_L = (CW+1)'(QDEPTH);

  // Queue storage: data only, never reset; validity lives in filled_q.
  logic [ADDR_W-1:0] pc_q   [QDEPTH];
  logic [31:0]       data_q [QDEPTH];

  // Control state.
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [QDEPTH-1:0] filled_q;
  logic [PW-1:0]     head_q, tail_q, fill_q;
  logic [CW-1:0]     used_q;   // reserved entries (filled or not)
  logic [CW-1:0]     pend_q;   // reserved entries still waiting for data
  logic [CW-1:0]     drop_q;   // stale responses still to be discarded
  logic              err_q;

  logic [CW:0] occ;
  logic        req_fire, fd_fire;
  logic        rsp_drop, rsp_fill, rsp_err;
  logic        rsp_consumed;

  // Memory slots are committed both to live entries and to stale
  // responses still in flight, so both count against the queue depth.
  assign occ            = {1'b0, used_q} + {1'b0, drop_q};
  assign imem_req_valid = !rst && !redirect_valid && (occ < QDEPTH_L);
  assign imem_req_addr  = fetch_pc_q;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign fd_fire  = fd_valid && fd_ready;

  assign rsp_drop     = imem_rsp_valid && (drop_q != '0);
  assign rsp_fill     = imem_rsp_valid && (drop_q == '0) && (pend_q != '0);
  assign rsp_err      = imem_rsp_valid && (drop_q == '0) && (pend_q == '0);
  assign rsp_consumed = rsp_drop || rsp_fill;

  // Head entry drives decode straight from registers; fields read as zero
  // while the head is empty.
  assign fd_valid    = filled_q[head_q];
  assign fd_instr    = fd_valid ? data_q[head_q] : '0;
  assign fd_pc       = fd_valid ? pc_q[head_q]   : '0;
  assign fd_pc_plus4 = fd_pc + ADDR_W'(4);
  assign err_rsp     = err_q;

  always_ff @(posedge clk) begin
    if (req_fire) pc_q[tail_q] <= fetch_pc_q;
    if (rsp_fill) data_q[fill_q] <= imem_rsp_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      filled_q   <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      used_q     <= '0;
      pend_q     <= '0;
      drop_q     <= '0;
      err_q      <= 1'b0;
    end else if (redirect_valid) begin
      // Every outstanding request becomes stale; a response arriving in
      // this same cycle is already accounted for here.
      fetch_pc_q <= {redirect_pc[ADDR_W-1:2], 2'b00};
      filled_q   <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      used_q     <= '0;
      pend_q     <= '0;
      drop_q     <= drop_q + pend_q - CW'(rsp_consumed);
      if (rsp_err) err_q <= 1'b1;
    end else begin
      // Push, fill and pop target distinct entries whenever they coincide.
      if (req_fire) begin
        filled_q[tail_q] <= 1'b0;
        tail_q           <= tail_q + 1'b1;
        fetch_pc_q       <= fetch_pc_q + ADDR_W'(4);
      end
      if (rsp_fill) begin
        filled_q[fill_q] <= 1'b1;
        fill_q           <= fill_q + 1'b1;
      end
      if (fd_fire) begin
        filled_q[head_q] <= 1'b0;
        head_q           <= head_q + 1'b1;
      end
      if (rsp_drop) drop_q <= drop_q - 1'b1;
      if (rsp_err)  err_q  <= 1'b1;
      used_q <= used_q + CW'(req_fire) - CW'(fd_fire);
      pend_q <= pend_q + CW'(req_fire) - CW'(rsp_fill);
    end
  end

endmodule
